// File: rtl/sobel_window_loader.sv
// sobel_window_loader: loads a 3x3 pixel window from image memory and keeps
// it current as the scan controller moves right, left or up.
// A full load reads 9 pixels. A move reads only the 3 newly exposed pixels
// and shifts the other 6.
// Ports:
//   clk, n_reset                  clock, async active-low reset
//   i_load_start, i_shift_start   one-cycle requests (load wins if both)
//   i_shift_dir                   01 right, 10 left, 11 up, 00 invalid
//   i_win_addr, i_length          top-left address after move, row length
//   o_mem_read/o_mem_addr         read request and address to pixel memory
//   i_mem_rdata/i_mem_ready       read data, beat accept
//   o_window                      pixel (r,c) at [PIX_W*(3r+c) +: PIX_W]
//   o_window_valid                set by first completed full load
//   o_busy, o_done                request in progress, commit pulse
module sobel_window_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned PIX_W  = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 i_load_start,
  input  logic                 i_shift_start,
  input  logic [1:0]           i_shift_dir,
  input  logic [ADDR_W-1:0]    i_win_addr,
  input  logic [11:0]          i_length,
  output logic                 o_mem_read,
  output logic [ADDR_W-1:0]    o_mem_addr,
  input  logic [PIX_W-1:0]     i_mem_rdata,
  input  logic                 i_mem_ready,
  output logic [9*PIX_W-1:0]   o_window,
  output logic                 o_window_valid,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_RIGHT = 2'b01;
  localparam logic [1:0] OP_LEFT  = 2'b10;
  localparam logic [1:0] OP_UP    = 2'b11;

  typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;
  typedef logic [PIX_W-1:0] pix_t;

  state_t              r_state, w_state_nx;
  logic [1:0]          r_op, w_op_nx;
  logic [ADDR_W-1:0]   r_base, w_base_nx;
  logic [ADDR_W-1:0]   r_len, w_len_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [ADDR_W-1:0]   r_mem_addr, w_addr_nx;
  logic                r_mem_read, w_read_nx;
  logic                r_busy, w_busy_nx;
  logic                r_done, w_done_nx;
  logic                r_valid, w_valid_nx;
  pix_t                r_stage [9];
  pix_t                r_win   [9];
  pix_t                w_stage_nx [9];
  pix_t                w_win_nx   [9];
  pix_t                w_fill     [9];
  pix_t                w_commit   [9];
  logic                w_start_ok, w_last;
  logic [1:0]          w_start_op;

  // Address of beat k: A + row*L + col, with the (row,col) set per operation.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [1:0] op,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] l,
                                                  input logic [CNT_W-1:0] k);
    logic [1:0]        row, col;
    logic [ADDR_W-1:0] roff;
    row = 2'd0;
    col = 2'd0;
    case (op)
      OP_LOAD: begin
        case (k)
          4'd0, 4'd1, 4'd2: row = 2'd0;
          4'd3, 4'd4, 4'd5: row = 2'd1;
          default:          row = 2'd2;
        endcase
        case (k)
          4'd0, 4'd3, 4'd6: col = 2'd0;
          4'd1, 4'd4, 4'd7: col = 2'd1;
          default:          col = 2'd2;
        endcase
      end
      OP_RIGHT: begin row = 2'(k); col = 2'd2; end
      OP_LEFT:  begin row = 2'(k); col = 2'd0; end
      default:  begin row = 2'd2;  col = 2'(k); end
    endcase
    case (row)
      2'd0:    roff = '0;
      2'd1:    roff = l;
      default: roff = l << 1;
    endcase
    return a + roff + ADDR_W'(col);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // Next state, beat sequencing and window commit.
  always_comb begin
    w_state_nx = r_state;
    w_op_nx    = r_op;
    w_base_nx  = r_base;
    w_len_nx   = r_len;
    w_cnt_nx   = r_cnt;
    w_addr_nx  = r_mem_addr;
    w_read_nx  = r_mem_read;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_valid_nx = r_valid;
    w_stage_nx = r_stage;
    w_win_nx   = r_win;
    w_start_op = i_load_start ? OP_LOAD : i_shift_dir;
    w_start_ok = i_load_start |
                 (i_shift_start & r_valid & (i_shift_dir != 2'b00));
    w_last     = (r_op == OP_LOAD) ? (r_cnt == CNT_W'(8)) : (r_cnt == CNT_W'(2));

    // Staging as it will look once the current beat is captured.
    w_fill = r_stage;
    w_fill[r_cnt] = i_mem_rdata;

    w_commit = r_win;
    for (int i = 0; i < 3; i++) begin
      case (r_op)
        OP_LOAD: begin
          w_commit[3*i]   = w_fill[3*i];
          w_commit[3*i+1] = w_fill[3*i+1];
          w_commit[3*i+2] = w_fill[3*i+2];
        end
        OP_RIGHT: begin
          w_commit[3*i]   = r_win[3*i+1];
          w_commit[3*i+1] = r_win[3*i+2];
          w_commit[3*i+2] = w_fill[i];
        end
        OP_LEFT: begin
          w_commit[3*i]   = w_fill[i];
          w_commit[3*i+1] = r_win[3*i];
          w_commit[3*i+2] = r_win[3*i+1];
        end
        default: begin
          w_commit[i]     = r_win[3+i];
          w_commit[3+i]   = r_win[6+i];
          w_commit[6+i]   = w_fill[i];
        end
      endcase
    end

    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nx = S_READ;
          w_op_nx    = w_start_op;
          w_base_nx  = i_win_addr;
          w_len_nx   = ADDR_W'(i_length);
          w_cnt_nx   = '0;
          w_addr_nx  = beat_addr(w_start_op, i_win_addr, ADDR_W'(i_length), '0);
          w_read_nx  = 1'b1;
          w_busy_nx  = 1'b1;
        end
      end
      default: begin
        if (i_mem_ready) begin
          w_stage_nx = w_fill;
          if (w_last) begin
            // Whole window updates on the last-beat edge only.
            w_state_nx = S_IDLE;
            w_read_nx  = 1'b0;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
            w_cnt_nx   = '0;
            w_win_nx   = w_commit;
            if (r_op == OP_LOAD) w_valid_nx = 1'b1;
          end else begin
            w_cnt_nx  = r_cnt + CNT_W'(1);
            w_addr_nx = beat_addr(r_op, r_base, r_len, r_cnt + CNT_W'(1));
          end
        end
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_op       <= OP_LOAD;
      r_base     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_mem_read <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      for (int p = 0; p < 9; p++) begin
        r_stage[p] <= '0;
        r_win[p]   <= '0;
      end
    end else begin
      r_op       <= w_op_nx;
      r_base     <= w_base_nx;
      r_len      <= w_len_nx;
      r_cnt      <= w_cnt_nx;
      r_mem_addr <= w_addr_nx;
      r_mem_read <= w_read_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_valid    <= w_valid_nx;
      r_stage    <= w_stage_nx;
      r_win      <= w_win_nx;
    end
  end

  // Flatten the window register onto the output bus.
  always_comb begin
    o_window = '0;
    for (int p = 0; p < 9; p++) o_window[PIX_W*p +: PIX_W] = r_win[p];
  end

  assign o_mem_read     = r_mem_read;
  assign o_mem_addr     = r_mem_addr;
  assign o_window_valid = r_valid;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_sobel_window_loader.sv
// Bench for sobel_window_loader: directed spec scenarios plus random moves,
// checked against a 3x3 window model and an expected read-address list.
`timescale 1ns/1ps
module tb_sobel_window_loader;
  logic        clk = 1'b0;
  logic        n_reset;
  logic        i_load_start, i_shift_start;
  logic [1:0]  i_shift_dir;
  logic [15:0] i_win_addr;
  logic [11:0] i_length;
  logic        o_mem_read;
  logic [15:0] o_mem_addr;
  logic [7:0]  i_mem_rdata;
  logic        i_mem_ready;
  logic [71:0] o_window;
  logic        o_window_valid, o_busy, o_done;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  key = 8'h00;
  int          stall_cfg = 0;
  int          scnt = 0;
  logic [15:0] acc_q[$];
  logic [7:0]  mwin[9];
  bit          mvalid = 1'b0;

  sobel_window_loader #(.ADDR_W(16), .PIX_W(8)) dut (
    .clk(clk), .n_reset(n_reset),
    .i_load_start(i_load_start), .i_shift_start(i_shift_start),
    .i_shift_dir(i_shift_dir), .i_win_addr(i_win_addr), .i_length(i_length),
    .o_mem_read(o_mem_read), .o_mem_addr(o_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .o_window(o_window), .o_window_valid(o_window_valid),
    .o_busy(o_busy), .o_done(o_done));

  always #5 clk = ~clk;

  // Memory: pixel at address a is a[7:0] ^ key; ready after stall_cfg wait cycles per beat.
  assign i_mem_rdata = o_mem_addr[7:0] ^ key;
  assign i_mem_ready = (scnt >= stall_cfg);

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset)                     scnt <= 0;
    else if (o_mem_read && i_mem_ready) scnt <= 0;
    else if (o_mem_read)              scnt <= scnt + 1;
    else                              scnt <= 0;
  end

  always @(posedge clk)
    if (n_reset && o_mem_read && i_mem_ready) acc_q.push_back(o_mem_addr);

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] waddr(input logic [15:0] a, input logic [11:0] len,
                                        input int r, input int c);
    return 16'(int'(a) + r * int'(len) + c);
  endfunction

  function automatic logic [7:0] px(input logic [15:0] a);
    return a[7:0] ^ key;
  endfunction

  function automatic logic [71:0] model_vec();
    logic [71:0] v;
    for (int p = 0; p < 9; p++) v[8*p +: 8] = mwin[p];
    return v;
  endfunction

  task automatic run_op(input bit ld, input bit sh, input logic [1:0] dir,
                        input logic [15:0] a, input logic [11:0] len,
                        input int stall, input bit poke, input string tag);
    logic [15:0] exp_q[$];
    logic [7:0]  nw[9];
    logic [15:0] prev_addr;
    bit          acc, prev_stall;
    int          op, n, k, bad;
    acc = ld || (sh && mvalid && dir != 2'b00);
    op  = ld ? 0 : int'(dir);
    for (int p = 0; p < 9; p++) nw[p] = mwin[p];
    if (acc) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          int p;
          p = 3 * r + c;
          if (op == 0 || (op == 1 && c == 2) || (op == 2 && c == 0) || (op == 3 && r == 2))
            exp_q.push_back(waddr(a, len, r, c));
          case (op)
            0:       nw[p] = px(waddr(a, len, r, c));
            1:       nw[p] = (c < 2) ? mwin[p+1] : px(waddr(a, len, r, 2));
            2:       nw[p] = (c > 0) ? mwin[p-1] : px(waddr(a, len, r, 0));
            default: nw[p] = (r < 2) ? mwin[p+3] : px(waddr(a, len, 2, c));
          endcase
        end
    end
    acc_q.delete();
    stall_cfg = stall;
    @(negedge clk);
    i_load_start = ld; i_shift_start = sh; i_shift_dir = dir;
    i_win_addr = a; i_length = len;
    @(negedge clk);
    i_load_start = 1'b0; i_shift_start = 1'b0;
    chk({tag, "/busy0"}, 72'(o_busy), 72'(acc));
    chk({tag, "/read0"}, 72'(o_mem_read), 72'(acc));
    if (acc) begin
      chk({tag, "/addr0"}, 72'(o_mem_addr), 72'(exp_q[0]));
      if (poke) i_load_start = 1'b1;
      n = exp_q.size() * (stall + 1);
      k = 0; bad = 0;
      prev_addr = o_mem_addr;
      prev_stall = o_mem_read && !i_mem_ready;
      while (!o_done && k < 300) begin
        @(negedge clk);
        k++;
        if (poke && k == 1) i_load_start = 1'b0;
        if (!o_done && !o_mem_read) bad++;
        if (prev_stall && o_mem_addr !== prev_addr) bad++;
        prev_addr = o_mem_addr;
        prev_stall = o_mem_read && !i_mem_ready;
      end
      for (int p = 0; p < 9; p++) mwin[p] = nw[p];
      if (op == 0) mvalid = 1'b1;
      chk({tag, "/latency"}, 72'(k), 72'(n));
      chk({tag, "/rd_gap_or_addr_move"}, 72'(bad), 72'(0));
      chk({tag, "/done"}, 72'(o_done), 72'(1));
      chk({tag, "/busy_end"}, 72'(o_busy), 72'(0));
      chk({tag, "/window"}, o_window, model_vec());
      chk({tag, "/valid"}, 72'(o_window_valid), 72'(mvalid));
      chk({tag, "/nbeats"}, 72'(acc_q.size()), 72'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
        chk({tag, "/beat_addr"}, 72'(acc_q[i]), 72'(exp_q[i]));
      @(negedge clk);
      chk({tag, "/done_pulse"}, 72'(o_done), 72'(0));
      chk({tag, "/read_after"}, 72'(o_mem_read), 72'(0));
    end else begin
      bad = 0;
      repeat (6) begin
        @(negedge clk);
        if (o_mem_read || o_done) bad++;
      end
      chk({tag, "/ignored"}, 72'(bad), 72'(0));
      chk({tag, "/ignored_beats"}, 72'(acc_q.size()), 72'(0));
      chk({tag, "/window_kept"}, o_window, model_vec());
    end
  endtask

  initial begin
    logic [71:0] base_win;
    int          t;
    n_reset = 1'b0;
    i_load_start = 1'b0; i_shift_start = 1'b0; i_shift_dir = 2'b00;
    i_win_addr = '0; i_length = '0;
    for (int p = 0; p < 9; p++) mwin[p] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst/read", 72'(o_mem_read), 72'(0));
    chk("rst/addr", 72'(o_mem_addr), 72'(0));
    chk("rst/window", o_window, 72'(0));
    chk("rst/valid", 72'(o_window_valid), 72'(0));
    chk("rst/busy", 72'(o_busy), 72'(0));
    chk("rst/done", 72'(o_done), 72'(0));
    n_reset = 1'b1;

    base_win = 72'h16_15_14_0C_0B_0A_02_01_00;
    run_op(0, 1, 2'b01, 16'h0001, 12'd10, 0, 0, "shift_before_load");
    run_op(1, 0, 2'b00, 16'h0000, 12'd10, 0, 0, "load0");
    chk("load0/spec_window", o_window, base_win);
    run_op(0, 1, 2'b01, 16'h0001, 12'd10, 0, 0, "right");
    chk("right/spec_window", o_window, 72'h17_16_15_0D_0C_0B_03_02_01);
    run_op(0, 1, 2'b10, 16'h0000, 12'd10, 0, 0, "left");
    chk("left/spec_window", o_window, base_win);
    run_op(0, 1, 2'b11, 16'h000A, 12'd10, 0, 0, "up");
    chk("up/spec_window", o_window, 72'h20_1F_1E_16_15_14_0C_0B_0A);
    run_op(1, 0, 2'b00, 16'h0000, 12'd10, 2, 0, "load_stall");
    chk("load_stall/spec_window", o_window, base_win);
    run_op(0, 1, 2'b00, 16'h0001, 12'd10, 0, 0, "dir00");
    run_op(1, 0, 2'b00, 16'h0005, 12'd10, 0, 1, "load_while_busy");
    run_op(1, 1, 2'b01, 16'h0020, 12'd10, 1, 0, "load_and_shift");
    run_op(1, 0, 2'b00, 16'hFFFF, 12'd1, 0, 0, "wrap");
    chk("wrap/spec_window", o_window, 72'h03_02_01_02_01_00_01_00_FF);

    // Reset after the fourth accepted beat of a full load.
    acc_q.delete();
    stall_cfg = 0;
    @(negedge clk);
    i_load_start = 1'b1; i_win_addr = 16'h0100; i_length = 12'd10;
    @(negedge clk);
    i_load_start = 1'b0;
    t = 0;
    while (acc_q.size() < 4 && t < 50) begin @(negedge clk); t++; end
    chk("rst_mid/beats_before", 72'(acc_q.size()), 72'(4));
    n_reset = 1'b0;
    #1;
    chk("rst_mid/read", 72'(o_mem_read), 72'(0));
    chk("rst_mid/addr", 72'(o_mem_addr), 72'(0));
    chk("rst_mid/window", o_window, 72'(0));
    chk("rst_mid/valid", 72'(o_window_valid), 72'(0));
    chk("rst_mid/busy", 72'(o_busy), 72'(0));
    chk("rst_mid/done", 72'(o_done), 72'(0));
    for (int p = 0; p < 9; p++) mwin[p] = 8'h00;
    mvalid = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    run_op(1, 0, 2'b00, 16'h0000, 12'd10, 0, 0, "after_reset");
    chk("after_reset/spec_window", o_window, base_win);

    // Random moves with random pixel keys, geometry and stalls.
    for (int i = 0; i < 24; i++) begin
      int ty;
      key = 8'($urandom);
      ty = (i == 0) ? 0 : int'($urandom_range(0, 3));
      run_op(ty == 0, ty != 0, 2'(ty), 16'($urandom), 12'($urandom_range(1, 4095)),
             int'($urandom_range(0, 2)), 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
